wptr_full_burst: RTL and testbench
==================================

Name: wptr_full_burst

Overview:
- Write-side pointer/flag handler for the async FIFO.
- Successor to the single-increment write pointer block; generalised to multi-word burst writes.
- Adds an occupancy level, a programmable almost-full flag, a same-cycle write acknowledge and a sticky overflow flag.
- Sits in the write clock domain. Consumes the 2-flop-synchronised gray read pointer and drives the write address to the dual-port RAM and the gray write pointer to the read-side synchroniser.

Parameters:
- ADDR_SIZE, 4, RAM address width; DEPTH = 2^ADDR_SIZE entries; pointers are ADDR_SIZE+1 bits.
- INC_W, 3, width of burst count input; maximum burst = 2^INC_W-1 words.

Ports:
- wclk  input  1  write clock
- wrst_n  input  1  asynchronous active-low reset
- wreq  input  1  write request
- wnum  input  INC_W  words in this request; 0 = no-op
- af_thresh  input  ADDR_SIZE+1  almost-full threshold (level units)
- wovf_clr  input  1  clears wovf
- wq2_rptr  input  ADDR_SIZE+1  gray read pointer, already synchronised to wclk
- wack  output  1  combinational: request accepted this cycle
- waddr  output  ADDR_SIZE  RAM address of first word of accepted burst (wbin[ADDR_SIZE-1:0])
- wptr  output  ADDR_SIZE+1  registered gray write pointer
- wfull  output  1  registered full flag
- walmost_full  output  1  registered almost-full flag
- wlevel  output  ADDR_SIZE+1  registered occupancy as seen by write side, 0..DEPTH
- wovf  output  1  sticky overflow/rejected-write flag

Behaviour:
- Reset (wrst_n low, async, any time incl. mid-burst): wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, wovf=0. wack is forced 0 while reset is asserted.
- rbin = gray-to-binary(wq2_rptr): rbin[i] = XOR of wq2_rptr[ADDR_SIZE:i].
- level = (wbin - rbin) mod 2^(ADDR_SIZE+1).
- free = DEPTH - level.
- wack = wreq & (wnum != 0) & (wnum <= free). All-or-nothing: partial bursts are never accepted.
- wbin_next = wbin + (wack ? wnum : 0), mod 2^(ADDR_SIZE+1); wrap-around is natural overflow.
- gray_next = wbin_next ^ (wbin_next >> 1).
- Each wclk rising edge: wbin<=wbin_next; wptr<=gray_next.
- Flags are registered from next-state values, so flags update on the same edge as the pointer:
  - level_next = wbin_next - rbin (mod);
  - wlevel <= level_next;
  - wfull <= (level_next == DEPTH);
  - walmost_full <= (level_next >= af_thresh).
- af_thresh=0: walmost_full is 1 after the first post-reset edge. af_thresh>DEPTH: walmost_full is never asserted.
- Equivalence: for wnum=1 traffic, wfull must match the classic gray compare: gray_next == {~rptr[MSB:MSB-1], rptr[rest]}.
- wovf: set on any edge where wreq & wnum!=0 & !wack. Cleared by wovf_clr. Set wins over clear in the same cycle.
- wreq with wnum=0: no-op, wack=0, no overflow.
- The read pointer advancing in the same cycle as a write only reduces level via wq2_rptr. Computation is conservative: level is never under-reported, because the read pointer is seen late.
- Latency: wack is combinational (same cycle). waddr/wptr/flags reflect an accepted burst one edge later.
- Caller writes RAM words at waddr..waddr+wnum-1 (mod DEPTH) in the acknowledged cycle.

Test Plan:
1. Defaults; reset, wq2_rptr=0, 16× (wreq=1, wnum=1) -> wack=1 each cycle; wptr sequence 1,3,2,6,...; after 16th edge wfull=1, wlevel=16, wptr=5'h18. 17th request -> wack=0, wovf=1, pointer unchanged.
2. Burst: reset, wnum=7 twice -> wlevel=7 then 14, waddr=0 then 7. Third wnum=3 -> wack=0, wovf=1. Then wnum=2 -> accepted, wfull=1, wlevel=16.
3. Almost-full: af_thresh=12, single writes -> walmost_full rises on the edge where wlevel becomes 12. Reader advances wq2_rptr to gray(2) -> wlevel=10 after next edge, walmost_full=0.
4. Wrap-around: hold wq2_rptr tracking wptr minus 3 words over 40 single writes -> wbin wraps 31->0; wfull never set; wlevel stays 3; waddr wraps 15->0.
5. wovf priority: on full FIFO assert wovf_clr and a rejected wreq together -> wovf stays 1; clr alone next cycle -> wovf=0.
6. Async reset mid-burst: wlevel=9, assert wrst_n low between edges -> all outputs 0 immediately, wack=0. Release -> normal operation from wptr=0.

Source files
------------

// File: rtl/wptr_full_burst_if.sv
// Write-side bus of the burst write-pointer block: request/burst inputs,
// synchronised read pointer, and the pointer/flag outputs.
interface wptr_full_burst_if #(
  parameter int ADDR_SIZE = 4,
  parameter int INC_W     = 3
);
  logic                 wreq;
  logic [INC_W-1:0]     wnum;
  logic [ADDR_SIZE:0]   af_thresh;
  logic                 wovf_clr;
  logic [ADDR_SIZE:0]   wq2_rptr;
  logic                 wack;
  logic [ADDR_SIZE-1:0] waddr;
  logic [ADDR_SIZE:0]   wptr;
  logic                 wfull;
  logic                 walmost_full;
  logic [ADDR_SIZE:0]   wlevel;
  logic                 wovf;

  // The writer drives requests and sees acknowledges/flags
  modport master (
    output wreq, wnum, af_thresh, wovf_clr, wq2_rptr,
    input  wack, waddr, wptr, wfull, walmost_full, wlevel, wovf
  );

  // The pointer block consumes requests and produces pointer/flags
  modport slave (
    input  wreq, wnum, af_thresh, wovf_clr, wq2_rptr,
    output wack, waddr, wptr, wfull, walmost_full, wlevel, wovf
  );
endinterface

// File: rtl/wptr_full_burst.sv
// Write-clock-domain pointer and flag handler for the async FIFO with
// all-or-nothing multi-word burst writes, occupancy level, almost-full
// and a sticky overflow flag.
module wptr_full_burst #(
  parameter int ADDR_SIZE = 4,
  parameter int INC_W     = 3
) (
  input logic wclk,
  input logic wrst_n,
  wptr_full_burst_if.slave bus
);
  localparam int PW    = ADDR_SIZE + 1;
  localparam int SW    = ((PW > INC_W) ? PW : INC_W) + 1;
  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [PW-1:0]    wbin;
  logic [PW-1:0]    wptr_q;
  logic             wfull_q;
  logic             walmost_full_q;
  logic [PW-1:0]    wlevel_q;
  logic             wovf_q;

  logic [PW-1:0]    rbin;
  logic [PW-1:0]    level;
  logic [SW-1:0]    demand;
  logic             req_valid;
  logic             accept;
  logic [INC_W-1:0] incr;
  logic [PW-1:0]    wbin_next;
  logic [PW-1:0]    gray_next;
  logic [PW-1:0]    level_next;

  // Convert the synchronised gray read pointer back to binary
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(bus.wq2_rptr >> i);
    end
  end

  // Acceptance decision and next-state pointer/level; a burst is taken
  // only when every word fits, and nothing is acknowledged during reset
  always_comb begin
    level      = wbin - rbin;
    demand     = SW'(level) + SW'(bus.wnum);
    req_valid  = bus.wreq & (bus.wnum != '0);
    accept     = wrst_n & req_valid & (demand <= SW'(DEPTH));
    incr       = accept ? bus.wnum : '0;
    wbin_next  = wbin + PW'(incr);
    gray_next  = wbin_next ^ (wbin_next >> 1);
    level_next = wbin_next - rbin;
  end

  // Pointer and flags all advance together from the next-state values
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin           <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
    end else begin
      wbin           <= wbin_next;
      wptr_q         <= gray_next;
      wfull_q        <= (level_next == PW'(DEPTH));
      walmost_full_q <= (level_next >= bus.af_thresh);
      wlevel_q       <= level_next;
    end
  end

  // Sticky overflow: a rejected real request sets it and beats a clear
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf_q <= 1'b0;
    end else if (req_valid & ~accept) begin
      wovf_q <= 1'b1;
    end else if (bus.wovf_clr) begin
      wovf_q <= 1'b0;
    end
  end

  assign bus.wack         = accept;
  assign bus.waddr        = wbin[ADDR_SIZE-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.wovf         = wovf_q;
endmodule

// File: tb/tb_wptr_full_burst.sv
// Self-checking bench for wptr_full_burst: directed scenarios with literal
// expectations plus a word-count model compared on every falling edge.
module tb_wptr_full_burst;
  localparam int ADDR_SIZE = 4;
  localparam int INC_W     = 3;
  localparam int DEPTH     = 16;
  localparam int PMOD      = 32;

  logic wclk = 1'b0;
  logic wrst_n;
  int   rd_count = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  int   m_wr  = 0;
  int   m_lvl = 0;
  bit   m_full = 0;
  bit   m_af   = 0;
  bit   m_ovf  = 0;
  bit   m_a    = 0;

  logic       ack_seen;
  logic [3:0] addr_seen;

  wptr_full_burst_if #(.ADDR_SIZE(ADDR_SIZE), .INC_W(INC_W)) bus ();

  wptr_full_burst #(.ADDR_SIZE(ADDR_SIZE), .INC_W(INC_W)) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .bus   (bus)
  );

  // Free-running write clock, period 10
  always #5 wclk = ~wclk;

  function automatic int gray_of(int n);
    int b;
    b = n % PMOD;
    return b ^ (b >> 1);
  endfunction

  // Acceptance from total words written/read: fits when level+wnum <= DEPTH
  function automatic bit model_ack();
    int lvl;
    lvl = m_wr - rd_count;
    return bus.wreq && (bus.wnum != 0) && (int'(bus.wnum) <= DEPTH - lvl);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input int want);
    n_checks++;
    if (got === 32'(want)) n_pass++;
    else $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  task automatic applyStimulus(input bit req, input int num, input bit clr);
    bus.wreq     = req;
    bus.wnum     = 3'(num);
    bus.wovf_clr = clr;
    bus.wq2_rptr = 5'(gray_of(rd_count));
    #1;
    ack_seen  = bus.wack;
    addr_seen = bus.waddr;
    @(posedge wclk);
    #1;
  endtask

  task automatic doReset();
    bus.wreq     = 1'b0;
    bus.wnum     = '0;
    bus.wovf_clr = 1'b0;
    rd_count     = 0;
    bus.wq2_rptr = '0;
    wrst_n       = 1'b0;
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  // Behavioural model: counts words accepted; everything else derives from it
  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      m_wr = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      m_a = model_ack();
      if (m_a) m_wr = m_wr + int'(bus.wnum);
      m_lvl  = m_wr - rd_count;
      m_full = (m_lvl == DEPTH);
      m_af   = (m_lvl >= int'(bus.af_thresh));
      if (bus.wreq && bus.wnum != 0 && !m_a) m_ovf = 1;
      else if (bus.wovf_clr) m_ovf = 0;
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge wclk) begin
    checkOutput("m_wack",   bus.wack,         int'(wrst_n === 1'b1 && model_ack()));
    checkOutput("m_wptr",   bus.wptr,         gray_of(m_wr));
    checkOutput("m_waddr",  bus.waddr,        m_wr % DEPTH);
    checkOutput("m_wlevel", bus.wlevel,       m_lvl);
    checkOutput("m_wfull",  bus.wfull,        int'(m_full));
    checkOutput("m_walmf",  bus.walmost_full, int'(m_af));
    checkOutput("m_wovf",   bus.wovf,         int'(m_ovf));
  end

  // Directed scenarios with hand-computed expectations
  initial begin
    int seq[4];
    int wr;
    seq = '{1, 3, 2, 6};
    bus.wreq = 0; bus.wnum = 0; bus.wovf_clr = 0; bus.wq2_rptr = 0;
    bus.af_thresh = 5'd14;
    wrst_n = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    wrst_n = 1'b1;

    // Single-word fill to full, then one rejected request
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 1, 0);
      checkOutput("t1_wack", ack_seen, 1);
      if (i < 4) checkOutput("t1_wptr_seq", bus.wptr, seq[i]);
    end
    checkOutput("t1_wfull", bus.wfull, 1);
    checkOutput("t1_wlevel", bus.wlevel, 16);
    checkOutput("t1_wptr_full", bus.wptr, 'h18);
    applyStimulus(1, 1, 0);
    checkOutput("t1_rej_wack", ack_seen, 0);
    checkOutput("t1_wovf", bus.wovf, 1);
    checkOutput("t1_wptr_hold", bus.wptr, 'h18);

    // Bursts, zero-length no-op and all-or-nothing rejection
    doReset();
    applyStimulus(1, 0, 0);
    checkOutput("t2_noop_wack", ack_seen, 0);
    checkOutput("t2_noop_wovf", bus.wovf, 0);
    applyStimulus(1, 7, 0);
    checkOutput("t2_b1_wack", ack_seen, 1);
    checkOutput("t2_b1_waddr", addr_seen, 0);
    checkOutput("t2_b1_wlevel", bus.wlevel, 7);
    applyStimulus(1, 7, 0);
    checkOutput("t2_b2_waddr", addr_seen, 7);
    checkOutput("t2_b2_wlevel", bus.wlevel, 14);
    applyStimulus(1, 3, 0);
    checkOutput("t2_b3_wack", ack_seen, 0);
    checkOutput("t2_b3_wovf", bus.wovf, 1);
    applyStimulus(1, 2, 0);
    checkOutput("t2_b4_wack", ack_seen, 1);
    checkOutput("t2_b4_waddr", addr_seen, 14);
    checkOutput("t2_b4_wfull", bus.wfull, 1);
    checkOutput("t2_b4_wlevel", bus.wlevel, 16);

    // Almost-full threshold and read pointer catching up
    doReset();
    bus.af_thresh = 5'd12;
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1, 1, 0);
      if (i == 11) checkOutput("t3_af_below", bus.walmost_full, 0);
    end
    checkOutput("t3_af_at", bus.walmost_full, 1);
    checkOutput("t3_wlevel12", bus.wlevel, 12);
    rd_count = 2;
    applyStimulus(0, 0, 0);
    checkOutput("t3_wlevel10", bus.wlevel, 10);
    checkOutput("t3_af_drop", bus.walmost_full, 0);

    // Pointer wrap with the reader trailing close behind
    doReset();
    bus.af_thresh = 5'd20;
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    wr = 2;
    for (int i = 0; i < 40; i++) begin
      rd_count = wr - 2;
      applyStimulus(1, 1, 0);
      wr++;
      checkOutput("t4_wlevel", bus.wlevel, 3);
      checkOutput("t4_wfull", bus.wfull, 0);
    end
    checkOutput("t4_wptr_wrap", bus.wptr, 'h0f);
    checkOutput("t4_waddr_wrap", bus.waddr, 10);

    // Overflow set has priority over clear
    doReset();
    bus.af_thresh = 5'd14;
    applyStimulus(1, 7, 0);
    applyStimulus(1, 7, 0);
    applyStimulus(1, 2, 0);
    applyStimulus(1, 1, 0);
    checkOutput("t5_wovf_set", bus.wovf, 1);
    applyStimulus(1, 1, 1);
    checkOutput("t5_clr_rej_wack", ack_seen, 0);
    checkOutput("t5_wovf_prio", bus.wovf, 1);
    applyStimulus(0, 0, 1);
    checkOutput("t5_wovf_clr", bus.wovf, 0);

    // Asynchronous reset in the middle of a cycle
    doReset();
    bus.af_thresh = 5'd5;
    applyStimulus(1, 7, 0);
    applyStimulus(1, 2, 0);
    checkOutput("t6_wlevel9", bus.wlevel, 9);
    checkOutput("t6_af_pre", bus.walmost_full, 1);
    bus.wreq = 1'b1;
    bus.wnum = 3'd1;
    #2;
    wrst_n = 1'b0;
    #1;
    checkOutput("t6_rst_wack", bus.wack, 0);
    checkOutput("t6_rst_wptr", bus.wptr, 0);
    checkOutput("t6_rst_wlevel", bus.wlevel, 0);
    checkOutput("t6_rst_wfull", bus.wfull, 0);
    checkOutput("t6_rst_af", bus.walmost_full, 0);
    checkOutput("t6_rst_waddr", bus.waddr, 0);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    applyStimulus(1, 1, 0);
    checkOutput("t6_post_wack", ack_seen, 1);
    checkOutput("t6_post_wptr", bus.wptr, 1);
    checkOutput("t6_post_wlevel", bus.wlevel, 1);

    applyStimulus(0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
